mem_bus_fabric: RTL and testbench

Parametrised memory-bus fabric that replaces hand-wired per-peripheral valid/ready/rdata gluing between the PicoRV32 native memory port and N slaves (SRAM, GPIO, UART, QSPI, ...). Each slave has a base/mask address window, and decode is registered. Each transaction tracks a single outstanding access with a watchdog timeout. Unmapped or hung accesses complete with an error word plus a sticky error report, so the CPU never stalls forever.

---
 rtl/mem_bus_pkg.sv | 27 ++
 rtl/mem_bus_decode.sv | 33 +++
 rtl/mem_bus_fabric.sv | 159 +++++++++++++++
 tb/tb_mem_bus_fabric.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and helpers for the memory-bus fabric: FSM encoding, error
// cause codes and a slot extractor for the packed per-slave vectors.
package mem_bus_pkg;

  localparam int MAX_SLAVES = 16;
  localparam int SLOT_VEC_W = MAX_SLAVES * 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_RESP   = 2'd2,
    ST_ERR    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_DECODE  = 2'b01,
    CAUSE_TIMEOUT = 2'b10
  } cause_t;

  // Callers zero-extend their packed vector to the maximum slot count.
  function automatic logic [31:0] slot32(input logic [SLOT_VEC_W-1:0] vec,
                                         input int idx);
    return vec[idx*32 +: 32];
  endfunction

endpackage

// File: rtl/mem_bus_decode.sv
// Address decoder: base/mask window match per slave, one-hot hit with
// priority to the lowest index, plus a miss flag when nothing matches.
module mem_bus_decode
  import mem_bus_pkg::*;
#(
  parameter int                        NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*32-1:0]  SLV_BASE   = {32'h0040_0000, 32'h0020_0000,
                                                     32'h0010_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*32-1:0]  SLV_MASK   = {4{32'hFFF0_0000}}
) (
  input  logic [31:0]           addr,
  output logic [NUM_SLAVES-1:0] hit,
  output logic                  miss
);

  localparam logic [SLOT_VEC_W-1:0] BASE_EXT = SLOT_VEC_W'(SLV_BASE);
  localparam logic [SLOT_VEC_W-1:0] MASK_EXT = SLOT_VEC_W'(SLV_MASK);

  logic found;

  always_comb begin
    hit   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (!found && ((addr & slot32(MASK_EXT, i)) == slot32(BASE_EXT, i))) begin
        hit[i] = 1'b1;
        found  = 1'b1;
      end
    end
    miss = !found;
  end

endmodule

// File: rtl/mem_bus_fabric.sv
// PicoRV32 native-port fabric: registered decode, single outstanding access,
// watchdog timeout, error-word completion and a sticky first-error report.
module mem_bus_fabric
  import mem_bus_pkg::*;
#(
  parameter int                        NUM_SLAVES     = 4,
  parameter logic [NUM_SLAVES*32-1:0]  SLV_BASE       = {32'h0040_0000, 32'h0020_0000,
                                                         32'h0010_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*32-1:0]  SLV_MASK       = {4{32'hFFF0_0000}},
  parameter int                        TIMEOUT_CYCLES = 255,
  parameter logic [31:0]               ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     m_valid,
  input  logic                     m_instr,
  input  logic [31:0]              m_addr,
  input  logic [31:0]              m_wdata,
  input  logic [3:0]               m_wstrb,
  output logic                     m_ready,
  output logic [31:0]              m_rdata,
  output logic [NUM_SLAVES-1:0]    s_valid,
  output logic                     s_instr,
  output logic [31:0]              s_addr,
  output logic [31:0]              s_wdata,
  output logic [3:0]               s_wstrb,
  input  logic [NUM_SLAVES-1:0]    s_ready,
  input  logic [NUM_SLAVES*32-1:0] s_rdata,
  output logic                     err_irq,
  output logic [1:0]               err_cause,
  output logic [31:0]              err_addr,
  input  logic                     err_clr
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t                  state, nxt;
  logic [NUM_SLAVES-1:0]   sel;
  logic                    miss_q;
  logic [15:0]             cnt;
  logic [NUM_SLAVES-1:0]   dec_hit;
  logic                    dec_miss;
  logic [SLOT_VEC_W-1:0]   rdata_ext;
  logic [31:0]             rd_sel;
  logic                    rdy_sel;
  logic                    capture;
  logic                    err_evt;
  logic [1:0]              err_cause_nxt;

  mem_bus_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .SLV_BASE   (SLV_BASE),
    .SLV_MASK   (SLV_MASK)
  ) u_decode (
    .addr (m_addr),
    .hit  (dec_hit),
    .miss (dec_miss)
  );

  assign rdata_ext = SLOT_VEC_W'(s_rdata);
  assign rdy_sel   = |(s_ready & sel);

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel[i]) rd_sel = slot32(rdata_ext, i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= nxt;
  end

  // A decode miss still spends one ACTIVE cycle (with no s_valid) so that
  // hits and misses share the same registered-decode completion timing.
  always_comb begin
    nxt           = state;
    s_valid       = '0;
    m_ready       = 1'b0;
    capture       = 1'b0;
    err_evt       = 1'b0;
    err_cause_nxt = CAUSE_NONE;
    case (state)
      ST_IDLE: begin
        if (m_valid) nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (miss_q) begin
          nxt           = ST_ERR;
          err_evt       = 1'b1;
          err_cause_nxt = CAUSE_DECODE;
        end else begin
          s_valid = sel;
          if (rdy_sel) begin
            nxt     = ST_RESP;
            capture = 1'b1;
          end else if (cnt == TO_LAST) begin
            nxt           = ST_ERR;
            err_evt       = 1'b1;
            err_cause_nxt = CAUSE_TIMEOUT;
          end
        end
      end
      ST_RESP: begin
        m_ready = 1'b1;
        nxt     = ST_IDLE;
      end
      ST_ERR: begin
        m_ready = 1'b1;
        nxt     = ST_IDLE;
      end
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_instr   <= 1'b0;
      s_addr    <= '0;
      s_wdata   <= '0;
      s_wstrb   <= '0;
      sel       <= '0;
      miss_q    <= 1'b0;
      cnt       <= '0;
      m_rdata   <= '0;
      err_irq   <= 1'b0;
      err_cause <= CAUSE_NONE;
      err_addr  <= '0;
    end else begin
      if (state == ST_IDLE && m_valid) begin
        s_instr <= m_instr;
        s_addr  <= m_addr;
        s_wdata <= m_wdata;
        s_wstrb <= m_wstrb;
        sel     <= dec_hit;
        miss_q  <= dec_miss;
      end

      if (state == ST_ACTIVE) cnt <= cnt + 16'd1;
      else                    cnt <= '0;

      if (capture)      m_rdata <= rd_sel;
      else if (err_evt) m_rdata <= ERR_RDATA;

      // First error wins; a clear coinciding with a new error keeps the new one.
      if (err_evt && (!err_irq || err_clr)) begin
        err_irq   <= 1'b1;
        err_cause <= err_cause_nxt;
        err_addr  <= s_addr;
      end else if (err_clr) begin
        err_irq   <= 1'b0;
        err_cause <= CAUSE_NONE;
        err_addr  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_fabric.sv
// Directed bench for mem_bus_fabric: reads, writes, decode miss, timeout,
// ignored foreign ready, error stickiness/clear and mid-transaction reset.
module tb_mem_bus_fabric;

  logic         clk;
  logic         rst_n;
  logic         m_valid;
  logic         m_instr;
  logic [31:0]  m_addr;
  logic [31:0]  m_wdata;
  logic [3:0]   m_wstrb;
  logic         m_ready;
  logic [31:0]  m_rdata;
  logic [3:0]   s_valid;
  logic         s_instr;
  logic [31:0]  s_addr;
  logic [31:0]  s_wdata;
  logic [3:0]   s_wstrb;
  logic [3:0]   s_ready;
  logic [127:0] s_rdata;
  logic         err_irq;
  logic [1:0]   err_cause;
  logic [31:0]  err_addr;
  logic         err_clr;

  int checks;
  int failures;

  mem_bus_fabric #(
    .NUM_SLAVES     (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m_valid   (m_valid),
    .m_instr   (m_instr),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_wstrb   (m_wstrb),
    .m_ready   (m_ready),
    .m_rdata   (m_rdata),
    .s_valid   (s_valid),
    .s_instr   (s_instr),
    .s_addr    (s_addr),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .s_ready   (s_ready),
    .s_rdata   (s_rdata),
    .err_irq   (err_irq),
    .err_cause (err_cause),
    .err_addr  (err_addr),
    .err_clr   (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic req(input logic [31:0] addr, input logic [3:0] strb,
                     input logic [31:0] wdata, input logic instr);
    m_valid = 1'b1;
    m_addr  = addr;
    m_wstrb = strb;
    m_wdata = wdata;
    m_instr = instr;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; m_valid = 1'b0; m_instr = 1'b0; m_addr = '0; m_wdata = '0;
    m_wstrb = '0; s_ready = '0; s_rdata = '0; err_clr = 1'b0;
    tick(); tick();
    chk("rst_m_ready", 32'(m_ready), 32'd0);
    chk("rst_s_valid", 32'(s_valid), 32'd0);
    chk("rst_m_rdata", m_rdata, 32'd0);
    chk("rst_s_addr", s_addr, 32'd0);
    chk("rst_err_irq", 32'(err_irq), 32'd0);
    chk("rst_err_cause", 32'(err_cause), 32'd0);
    chk("rst_err_addr", err_addr, 32'd0);
    rst_n = 1'b1;
    tick();

    // Read slave1, ready on the first ACTIVE cycle.
    req(32'h0010_0004, 4'b0000, 32'h0, 1'b1);
    tick();
    chk("rd1_s_valid", 32'(s_valid), 32'h2);
    chk("rd1_s_addr", s_addr, 32'h0010_0004);
    chk("rd1_s_instr", 32'(s_instr), 32'd1);
    chk("rd1_no_ready", 32'(m_ready), 32'd0);
    m_valid = 1'b0;
    s_ready = 4'b0010;
    s_rdata[63:32] = 32'h1234_5678;
    tick();
    chk("rd1_m_ready", 32'(m_ready), 32'd1);
    chk("rd1_m_rdata", m_rdata, 32'h1234_5678);
    chk("rd1_s_valid_drop", 32'(s_valid), 32'd0);
    s_ready = '0;
    tick();
    chk("rd1_pulse_end", 32'(m_ready), 32'd0);

    // Write slave0, ready after five ACTIVE cycles; master bus changes meanwhile.
    req(32'h0000_0010, 4'b0011, 32'hA5A5_0F0F, 1'b0);
    s_rdata[31:0] = 32'h0BAD_F00D;
    tick();
    m_valid = 1'b0;
    m_wdata = 32'hFFFF_FFFF;
    m_wstrb = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      chk("wr_s_valid", 32'(s_valid), 32'h1);
      chk("wr_s_wdata", s_wdata, 32'hA5A5_0F0F);
      chk("wr_s_wstrb", 32'(s_wstrb), 32'h3);
      chk("wr_wait", 32'(m_ready), 32'd0);
      if (i == 4) s_ready = 4'b0001;
      tick();
    end
    chk("wr_m_ready", 32'(m_ready), 32'd1);
    chk("wr_err_irq", 32'(err_irq), 32'd0);
    s_ready = '0;
    m_wstrb = '0;
    tick();
    chk("wr_pulse_end", 32'(m_ready), 32'd0);

    // Foreign ready on slave3 while slave1 is selected.
    req(32'h0010_0020, 4'b0000, 32'h0, 1'b0);
    tick();
    m_valid = 1'b0;
    chk("ign_s_valid", 32'(s_valid), 32'h2);
    s_ready = 4'b1000;
    s_rdata[127:96] = 32'h3333_3333;
    tick();
    chk("ign_no_ready1", 32'(m_ready), 32'd0);
    chk("ign_still_valid", 32'(s_valid), 32'h2);
    tick();
    chk("ign_no_ready2", 32'(m_ready), 32'd0);
    s_ready = 4'b0010;
    s_rdata[63:32] = 32'h1111_2222;
    tick();
    chk("ign_m_ready", 32'(m_ready), 32'd1);
    chk("ign_m_rdata", m_rdata, 32'h1111_2222);
    s_ready = '0;
    tick();

    // Decode miss.
    req(32'h8000_0000, 4'b0000, 32'h0, 1'b0);
    tick();
    m_valid = 1'b0;
    chk("miss_s_valid", 32'(s_valid), 32'd0);
    chk("miss_early_ready", 32'(m_ready), 32'd0);
    tick();
    chk("miss_m_ready", 32'(m_ready), 32'd1);
    chk("miss_m_rdata", m_rdata, 32'hDEAD_BEEF);
    chk("miss_s_valid2", 32'(s_valid), 32'd0);
    chk("miss_err_irq", 32'(err_irq), 32'd1);
    chk("miss_err_cause", 32'(err_cause), 32'h1);
    chk("miss_err_addr", err_addr, 32'h8000_0000);
    tick();
    chk("miss_pulse_end", 32'(m_ready), 32'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr1_err_irq", 32'(err_irq), 32'd0);
    chk("clr1_err_cause", 32'(err_cause), 32'd0);

    // Ready on the final watchdog cycle beats the timeout.
    req(32'h0020_0040, 4'b0000, 32'h0, 1'b0);
    tick();
    m_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("edge_s_valid", 32'(s_valid), 32'h4);
      if (i == 7) begin
        s_ready = 4'b0100;
        s_rdata[95:64] = 32'h2222_0008;
      end
      tick();
    end
    chk("edge_m_ready", 32'(m_ready), 32'd1);
    chk("edge_m_rdata", m_rdata, 32'h2222_0008);
    chk("edge_no_err", 32'(err_irq), 32'd0);
    s_ready = '0;
    tick();

    // Slave2 never ready: exactly eight cycles of s_valid, then timeout.
    req(32'h0020_0100, 4'b0000, 32'h0, 1'b0);
    tick();
    m_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("to_s_valid", 32'(s_valid), 32'h4);
      chk("to_wait", 32'(m_ready), 32'd0);
      tick();
    end
    chk("to_s_valid_drop", 32'(s_valid), 32'd0);
    chk("to_m_ready", 32'(m_ready), 32'd1);
    chk("to_m_rdata", m_rdata, 32'hDEAD_BEEF);
    chk("to_err_irq", 32'(err_irq), 32'd1);
    chk("to_err_cause", 32'(err_cause), 32'h2);
    chk("to_err_addr", err_addr, 32'h0020_0100);
    tick();

    // Second error while sticky: dropped.
    req(32'h9000_0004, 4'b0000, 32'h0, 1'b0);
    tick();
    m_valid = 1'b0;
    tick();
    chk("miss2_m_ready", 32'(m_ready), 32'd1);
    chk("miss2_err_cause", 32'(err_cause), 32'h2);
    chk("miss2_err_addr", err_addr, 32'h0020_0100);
    tick();

    // Clear coinciding with a new error: the new error is recorded.
    req(32'hA000_0000, 4'b0000, 32'h0, 1'b0);
    tick();
    m_valid = 1'b0;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clrhit_err_irq", 32'(err_irq), 32'd1);
    chk("clrhit_err_cause", 32'(err_cause), 32'h1);
    chk("clrhit_err_addr", err_addr, 32'hA000_0000);
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr2_err_irq", 32'(err_irq), 32'd0);
    chk("clr2_err_cause", 32'(err_cause), 32'd0);
    chk("clr2_err_addr", err_addr, 32'd0);

    // Asynchronous reset while ACTIVE.
    req(32'h0010_0008, 4'b0000, 32'h0, 1'b0);
    tick();
    m_valid = 1'b0;
    chk("rstmid_pre", 32'(s_valid), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_s_valid", 32'(s_valid), 32'd0);
    chk("rstmid_m_ready", 32'(m_ready), 32'd0);
    tick();
    chk("rstmid_m_ready2", 32'(m_ready), 32'd0);
    chk("rstmid_s_valid2", 32'(s_valid), 32'd0);
    rst_n = 1'b1;
    tick();
    req(32'h0000_0040, 4'b0000, 32'h0, 1'b0);
    tick();
    m_valid = 1'b0;
    chk("post_s_valid", 32'(s_valid), 32'h1);
    s_ready = 4'b0001;
    s_rdata[31:0] = 32'hCAFE_0001;
    tick();
    chk("post_m_ready", 32'(m_ready), 32'd1);
    chk("post_m_rdata", m_rdata, 32'hCAFE_0001);
    s_ready = '0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
